// File: rtl/reg32_pkg.sv
// rtl/reg32_pkg.sv - shared types and widths for the Reg32 serializer slice
//
// Contents:
//   REG32_W     : data word width (32)
//   CNT_W       : bit counter width (5)
//   ser_state_t : serializer FSM states (PARITY is only entered when
//                 REG32_SERIALIZER_PARITY_EN is defined)
package reg32_pkg;

    localparam int REG32_W = 32;
    localparam int CNT_W   = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } ser_state_t;

endpackage

// File: rtl/reg32_serializer_if.sv
// rtl/reg32_serializer_if.sv - word-in / bit-out bundle of the serializer
//
// Signals:
//   din        : word to transmit (source -> serializer)
//   din_valid  : source presents din
//   din_ready  : serializer can accept a word this cycle
//   sout       : serial data bit
//   sout_valid : sout carries a data or parity bit
//   done       : one-cycle pulse after the last bit of a frame
// Modports:
//   master : word source / serial consumer side (testbench, datapath)
//   slave  : serializer side
interface reg32_serializer_if;
    import reg32_pkg::*;

    logic [REG32_W-1:0] din;
    logic               din_valid;
    logic               din_ready;
    logic               sout;
    logic               sout_valid;
    logic               done;

    modport master (
        output din, din_valid,
        input  din_ready, sout, sout_valid, done
    );

    modport slave (
        input  din, din_valid,
        output din_ready, sout, sout_valid, done
    );

endinterface

// File: rtl/Reg32.sv
// rtl/Reg32.sv - 32-bit parallel-load register used as the capture stage
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, clears the register
//   en   : load enable, din is captured when high
//   din  : parallel input word
//   dout : registered output word
module Reg32
    import reg32_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [REG32_W-1:0] din,
    output logic [REG32_W-1:0] dout
);

    logic [REG32_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= din;
        end
    end

    assign dout = r_q;

endmodule

// File: rtl/reg32_serializer.sv
// rtl/reg32_serializer.sv - captures one 32-bit word and shifts it out bit-serially
//
// Optional feature macro: REG32_SERIALIZER_PARITY_EN
//   defined   : one even-parity bit follows the 32 data bits
//   undefined : DONE follows the last data bit, no parity logic
//
// Parameters:
//   MSB_FIRST  : 1 sends bit 31 first, 0 sends bit 0 first
//   IDLE_LEVEL : level on sout while no bit is valid
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset, aborts any frame without done
//   en  : global advance enable, all state holds while low
//   bus : reg32_serializer_if slave (din/din_valid/din_ready in,
//         sout/sout_valid/done out)
module reg32_serializer
    import reg32_pkg::*;
#(
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    reg32_serializer_if.slave   bus
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(REG32_W - 1);

    ser_state_t         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sout;
    logic               r_sout_valid;
    logic               r_done;

    ser_state_t         w_state_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_sout_next;
    logic               w_sout_valid_next;
    logic               w_done_next;

    logic               w_din_ready;
    logic               w_accept;
    logic [REG32_W-1:0] w_dout;
    logic [REG32_W-1:0] w_word_next;
    logic [CNT_W-1:0]   w_idx_next;

    assign w_din_ready   = (r_state == IDLE) && en;
    assign w_accept      = bus.din_valid && w_din_ready;
    assign bus.din_ready = w_din_ready;

    Reg32 u_capture (
        .clk  (clk),
        .rst  (rst),
        .en   (w_accept),
        .din  (bus.din),
        .dout (w_dout)
    );

    // Outputs are registered, so the bit shown after an edge is computed
    // from the word the capture register holds after that same edge: on
    // the accept edge that is din itself, otherwise the stable dout.
    assign w_word_next = w_accept ? bus.din : w_dout;
    assign w_idx_next  = MSB_FIRST ? (LAST_BIT - w_cnt_next) : w_cnt_next;

    // State register together with the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_sout       <= IDLE_LEVEL;
            r_sout_valid <= 1'b0;
            r_done       <= 1'b0;
        end else if (en) begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_sout       <= w_sout_next;
            r_sout_valid <= w_sout_valid_next;
            r_done       <= w_done_next;
        end
    end

    // Next-state and counter.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = SHIFT;
                    w_cnt_next   = '0;
                end
            end
            SHIFT: begin
                // Wraps 31 -> 0 on the last data bit.
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == LAST_BIT) begin
`ifdef REG32_SERIALIZER_PARITY_EN
                    w_state_next = PARITY;
`else
                    w_state_next = DONE;
`endif
                end
            end
`ifdef REG32_SERIALIZER_PARITY_EN
            PARITY: begin
                w_state_next = DONE;
            end
`endif
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Output values for the state being entered.
    always_comb begin
        w_sout_next       = IDLE_LEVEL;
        w_sout_valid_next = 1'b0;
        w_done_next       = 1'b0;
        case (w_state_next)
            SHIFT: begin
                w_sout_next       = w_word_next[w_idx_next];
                w_sout_valid_next = 1'b1;
            end
`ifdef REG32_SERIALIZER_PARITY_EN
            PARITY: begin
                w_sout_next       = ^w_word_next;
                w_sout_valid_next = 1'b1;
            end
`endif
            DONE: begin
                w_done_next = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.sout       = r_sout;
    assign bus.sout_valid = r_sout_valid;
    assign bus.done       = r_done;

endmodule

// File: tb/tb_reg32_serializer.sv
// tb/tb_reg32_serializer.sv - self-checking bench for reg32_serializer
module tb_reg32_serializer;

`ifdef REG32_SERIALIZER_PARITY_EN
    localparam int PAR_CYC = 1;
`else
    localparam int PAR_CYC = 0;
`endif

    logic clk;
    logic rst;
    logic en;

    reg32_serializer_if b_if ();
    reg32_serializer_if l_if ();

    reg32_serializer #(.MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (b_if)
    );

    reg32_serializer #(.MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (l_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    bit   q_msb[$];
    bit   q_lsb[$];
    bit   mon_on = 1'b0;
    logic last_en = 1'b0;
    logic p_sout, p_valid, p_done;
    int   done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_frame(input bit lsb_inst, input logic [31:0] w, input bit par);
        logic [31:0] word;
        word = w;
        for (int i = 0; i < 32; i++) begin
            if (lsb_inst) q_lsb.push_back(word[i]);
            else          q_msb.push_back(word[31-i]);
        end
`ifdef REG32_SERIALIZER_PARITY_EN
        if (lsb_inst) q_lsb.push_back(par);
        else          q_msb.push_back(par);
`else
        if (par) begin end
`endif
    endfunction

    // Scoreboard monitors: a new output appears only after an edge with en=1.
    always @(posedge clk) last_en <= en;

    always @(negedge clk) begin
        if (mon_on) begin
            if (!last_en) begin
                chk("stall hold sout", b_if.sout, p_sout);
                chk("stall hold sout_valid", b_if.sout_valid, p_valid);
                chk("stall hold done", b_if.done, p_done);
            end else begin
                if (b_if.sout_valid) begin
                    if (q_msb.size() == 0) chk("msb unexpected bit", 1, 0);
                    else                   chk("msb bit", b_if.sout, q_msb.pop_front());
                end
                if (b_if.done) done_cnt++;
                if (l_if.sout_valid) begin
                    if (q_lsb.size() == 0) chk("lsb unexpected bit", 1, 0);
                    else                   chk("lsb bit", l_if.sout, q_lsb.pop_front());
                end
            end
        end
        p_sout  <= b_if.sout;
        p_valid <= b_if.sout_valid;
        p_done  <= b_if.done;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_msb(input logic [31:0] w, input bit par);
        int t;
        t = 0;
        b_if.din       = w;
        b_if.din_valid = 1'b1;
        while (b_if.din_ready !== 1'b1 && t < 100) begin
            step();
            t++;
        end
        chk("ready before accept", b_if.din_ready, 1);
        push_frame(1'b0, w, par);
        step();
        b_if.din_valid = 1'b0;
        b_if.din       = $urandom();
    endtask

    // Called just after the accept edge; stalls en after bit stall_at is shown.
    task automatic wait_done(input int stall_at, input int stall_len, output int lat);
        int k;
        k = 0;
        while (b_if.done !== 1'b1 && k < 300) begin
            en = !(stall_len > 0 && k >= stall_at && k < stall_at + stall_len);
            step();
            k++;
        end
        en  = 1'b1;
        lat = k;
    endtask

    task automatic finish_frame(input int exp_lat, input int lat);
        chk("done seen", b_if.done, 1);
        chk("done latency", lat, exp_lat);
        step();
        chk("done single pulse", b_if.done, 0);
        chk("ready after done", b_if.din_ready, 1);
        chk("sout idle level", b_if.sout, 0);
        chk("all bits emitted", q_msb.size(), 0);
    endtask

    typedef struct {
        logic [31:0] word;
        int          stall_at;
        int          stall_len;
        bit          par;
        int          exp_lat;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   lat;
        int   k;
        int   d0;
        bit   seen_done;

        en             = 1'b1;
        rst            = 1'b1;
        b_if.din       = '0;
        b_if.din_valid = 1'b0;
        l_if.din       = '0;
        l_if.din_valid = 1'b0;

        vecs[0] = '{32'hA5A5A5A5,  0, 0, 1'b0, 32 + PAR_CYC};
        vecs[1] = '{32'h00000001,  0, 0, 1'b1, 32 + PAR_CYC};
        vecs[2] = '{32'hDEADBEEF,  0, 0, 1'b0, 32 + PAR_CYC};
        vecs[3] = '{32'hDEADBEEF, 10, 3, 1'b0, 35 + PAR_CYC};
        vecs[4] = '{32'hFFFFFFFF,  0, 0, 1'b0, 32 + PAR_CYC};
        vecs[5] = '{32'h00000000, 31, 2, 1'b0, 34 + PAR_CYC};

        // Reset state.
        repeat (3) step();
        chk("reset sout", b_if.sout, 0);
        chk("reset sout_valid", b_if.sout_valid, 0);
        chk("reset done", b_if.done, 0);
        chk("reset din_ready", b_if.din_ready, 1);
        chk("reset lsb sout idle1", l_if.sout, 1);
        chk("reset lsb sout_valid", l_if.sout_valid, 0);
        rst = 1'b0;
        step();
        en = 1'b0;
        #1;
        chk("din_ready follows en", b_if.din_ready, 0);
        en = 1'b1;
        #1;
        mon_on = 1'b1;

        // Table-driven frames, including stalls.
        for (int i = 0; i < 6; i++) begin
            accept_msb(vecs[i].word, vecs[i].par);
            wait_done(vecs[i].stall_at, vecs[i].stall_len, lat);
            finish_frame(vecs[i].exp_lat, lat);
        end

        // LSB-first instance.
        l_if.din       = 32'h80000000;
        l_if.din_valid = 1'b1;
        #1;
        chk("lsb ready", l_if.din_ready, 1);
        push_frame(1'b1, 32'h80000000, 1'b1);
        step();
        l_if.din_valid = 1'b0;
        l_if.din       = 32'hFFFFFFFF;
        k = 0;
        while (l_if.done !== 1'b1 && k < 100) begin
            step();
            k++;
        end
        chk("lsb done latency", k, 32 + PAR_CYC);
        step();
        chk("lsb all bits emitted", q_lsb.size(), 0);
        chk("lsb idle level", l_if.sout, 1);

        // Handshake under load: din_valid held during a frame.
        accept_msb(32'h0F0F0F0F, 1'b0);
        b_if.din       = 32'h12345678;
        b_if.din_valid = 1'b1;
        k = 0;
        seen_done = 1'b0;
        while (b_if.din_ready !== 1'b1 && k < 100) begin
            if (b_if.done === 1'b1) seen_done = 1'b1;
            step();
            k++;
        end
        chk("accept to accept period", k + 1, 34 + PAR_CYC);
        chk("done before ready", seen_done, 1);
        chk("busy frame bits emitted", q_msb.size(), 0);
        push_frame(1'b0, 32'h12345678, 1'b1);
        step();
        b_if.din_valid = 1'b0;
        wait_done(0, 0, lat);
        finish_frame(32 + PAR_CYC, lat);

        // Reset mid-frame at bit 16.
        accept_msb(32'hFFFFFFFF, 1'b0);
        repeat (16) step();
        chk("bit16 valid before reset", b_if.sout_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        q_msb.delete();
        chk("abort sout_valid", b_if.sout_valid, 0);
        chk("abort sout", b_if.sout, 0);
        chk("abort done", b_if.done, 0);
        chk("abort din_ready", b_if.din_ready, 1);
        d0 = done_cnt;
        repeat (40) step();
        chk("abort no done pulse", done_cnt, d0);
        chk("abort stays idle", b_if.sout_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/reg32_serializer.md
# reg32_serializer

Transmit-side counterpart to the 32-bit parallel-load register (`Reg32`). It accepts one 32-bit word through a valid/ready handshake, captures it, and shifts it out bit-serially on a single line with framing strobes, an optional parity bit, and a completion pulse. It sits between a `Reg32`-style parallel datapath and any bit-serial consumer, for example a link transmitter or a debug readback pin.

## Interface
Parameters:
- `MSB_FIRST`, default 1: 1 shifts bit 31 first; 0 shifts bit 0 first.
- `IDLE_LEVEL`, default 0: value driven on `sout` when no bit is valid.

Ports (clock and reset first):
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `en`  input  1  global advance enable; when 0, all state holds.
- `din`  input  32  word to transmit.
- `din_valid`  input  1  source presents `din`.
- `din_ready`  output  1  combinational: `(state==IDLE) && en`.
- `sout`  output  1  serial data, registered.
- `sout_valid`  output  1  `sout` carries a data or parity bit, registered.
- `done`  output  1  one-cycle pulse after the last bit, registered.

## Operation
- States: IDLE, SHIFT, PARITY (only present when the configuration macro is defined), DONE.
- **Rule that applies in every state:** when `en=0`, nothing changes. The state, counter, captured word, `sout`, `sout_valid` and `done` all keep their current values.
- **IDLE:**
  - `sout=IDLE_LEVEL`, `sout_valid=0`.
  - Accept occurs when `din_valid && din_ready`. On accept: capture `din`, clear the 5-bit counter, go to SHIFT.
  - If there is no accept, stay in IDLE.
- **SHIFT:**
  - `sout_valid=1`.
  - `sout` is the captured word indexed by `31-cnt` if `MSB_FIRST`, otherwise by `cnt`.
  - `cnt` increments on each `en` cycle.
  - When `cnt==31` and `en=1`, go to PARITY (macro defined) or to DONE (macro undefined). The counter wraps to 0.
- **PARITY:** `sout` = XOR of all 32 captured bits (even parity), `sout_valid=1`. After one `en` cycle, go to DONE.
- **DONE:** `done=1`, `sout_valid=0`, `sout=IDLE_LEVEL`. After one `en` cycle, go to IDLE.
- **`din_valid` while busy:** ignored, because `din_ready=0`. The source must hold `din` until it sees a handshake.
- **`din` changing after capture:** has no effect on the frame in flight.
- **`rst=1`:** takes priority over `en` and the handshake. It aborts any frame in progress without a `done` pulse.
- **Reset values:**
  - state IDLE, counter 0, captured word 0.
  - `sout=IDLE_LEVEL`, `sout_valid=0`, `done=0`.
  - `din_ready` is 1 whenever `en=1`.

## Timing
- **Accept:** handshake at edge N.
- **First bit:** valid after edge N.
- **Data bits:** bit k is valid after edge N+k, for k = 0..31, assuming `en=1` throughout.
- **Parity:** after edge N+32 (macro defined).
- **`done`:** after edge N+32 (macro undefined) or N+33 (macro defined). It is a single-cycle pulse.
- **`din_ready` returns:** after the `done` cycle.
- **Minimum frame period (accept to next accept):** 34 cycles without the macro, 35 with it.
- **Stalls:** each `en=0` cycle stretches the frame by exactly one cycle. No bit is skipped or duplicated in value.
- **Data path:** there is no combinational path from `din` to `sout`. `din_ready` depends combinationally on `en` and state only.

## Configuration
- Macro: `REG32_SERIALIZER_PARITY_EN`.
- **Defined:** the PARITY state exists and one even-parity bit follows the 32 data bits.
- **Undefined:** there is no PARITY state; DONE follows the last data bit directly, and no parity logic is synthesized.

## Structure
- **Shared package `reg32_pkg`** holds:
  - the state enum typedef `ser_state_t` (IDLE, SHIFT, PARITY, DONE);
  - `REG32_W = 32`;
  - `CNT_W = 5`.
- **Sub-module:** one instance of `Reg32` as the capture register.
  - Connections: `din` → `din`, `dout` → bit mux.
  - Its `en` is driven by `din_valid && din_ready`; its reset is `rst`.
  - The serializer indexes the stable `dout` with the counter rather than using a shifting register.

## Test plan
- **Basic MSB-first frame:** reset, then accept `0xA5A5A5A5` with `en=1`. Expect `sout` to read 1,0,1,0,0,1,0,1,… for 32 valid cycles. Then expect parity 0 (macro defined), then `done` high for one cycle.
- **Parity:** accept `0x00000001` with the macro defined. Expect 31 zeros, then 1, then parity bit 1. Then accept `0xDEADBEEF` and expect parity bit 0.
- **LSB-first:** with `MSB_FIRST=0`, accept `0x80000000`. Expect 31 zeros followed by a 1.
- **Stall:** deassert `en` for 3 cycles after bit 10 of `0xDEADBEEF`. Expect `sout` and `sout_valid` to hold, the bit sequence to be unchanged, and `done` delayed by exactly 3 cycles.
- **Handshake under load:** hold `din_valid=1` with `0x12345678` during a frame in progress. Expect `din_ready=0` until after `done`, then acceptance on the first IDLE cycle. Back-to-back frames are spaced 35 cycles apart (34 without the macro).
- **Reset mid-frame:** assert `rst` for 1 cycle at bit 16. Expect on the next cycle `sout_valid=0`, `sout=IDLE_LEVEL`, state IDLE, no `done` pulse, and `din_ready=1`.
